lods_pre_pipe: RTL and testbench

Parametrised, pipelined leading-one predictor for the sum of two unsigned operands, generalising lods_12_pre to any operand width W.
- Stage 1 predicts the leading-one position from (a | b) in parallel with the addition.
- Stage 2 corrects the prediction, which is off by at most one, using the registered sum.
- Valid/ready handshake on both sides and a saturating count of corrections.
- Sits ahead of the normalisation shifter in the FP add datapath.

---
 rtl/lods_pre_pipe_if.sv | 37 +++
 rtl/lods_pre_pipe.sv | 111 +++++++++++
 tb/tb_lods_pre_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lods_pre_pipe_if.sv
// ============================================================================
// Module   : lods_pre_pipe_if
// Brief    : Operand/result handshake bundle for the leading-one predictor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lods_pre_pipe_if #(
    parameter int W  = 11,
    parameter int PW = $clog2(W + 1),
    parameter int CW = 16
) ();
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    sum;
    logic [PW-1:0] c;
    logic          v;
    logic          corr;
    logic [CW-1:0] corr_cnt;
    logic          clr_cnt;

    modport master (
        output in_valid, a, b, out_ready, clr_cnt,
        input  in_ready, out_valid, sum, c, v, corr, corr_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready, clr_cnt,
        output in_ready, out_valid, sum, c, v, corr, corr_cnt
    );
endinterface

`default_nettype wire

// File: rtl/lods_pre_pipe.sv
// ============================================================================
// Module   : lods_pre_pipe
// Brief    : Two-stage leading-one predictor/corrector for a + b, W-bit operands.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lods_pre_pipe #(
    parameter int W  = 11,
    parameter int PW = $clog2(W + 1),
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    lods_pre_pipe_if.slave  bus
);

    logic          w_adv1;
    logic          w_adv2;
    logic [W-1:0]  w_or;
    logic [PW-1:0] w_pred;
    logic [PW-1:0] w_pred_inc;
    logic          w_carry_up;
    logic          w_out_xfer;

    logic          r_s1_valid;
    logic [W:0]    r_s1_sum;
    logic [PW-1:0] r_s1_pred;
    logic          r_s1_nz;

    logic          r_s2_valid;
    logic [W:0]    r_sum;
    logic [PW-1:0] r_c;
    logic          r_v;
    logic          r_corr;
    logic [CW-1:0] r_cnt;

    assign w_adv2     = ~r_s2_valid | bus.out_ready;
    assign w_adv1     = ~r_s1_valid | w_adv2;
    assign w_out_xfer = r_s2_valid & bus.out_ready;
    assign w_or       = bus.a | bus.b;

    // Highest set bit of a|b; the true sum MSB is this or one above it.
    always_comb begin
        w_pred = '0;
        for (int i = 0; i < W; i++) begin
            if (w_or[i]) begin
                w_pred = PW'(i);
            end
        end
    end

    assign w_pred_inc = r_s1_pred + {{(PW-1){1'b0}}, 1'b1};
    assign w_carry_up = r_s1_nz & r_s1_sum[w_pred_inc];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_pred  <= '0;
            r_s1_nz    <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sum  <= {1'b0, bus.a} + {1'b0, bus.b};
                r_s1_pred <= w_pred;
                r_s1_nz   <= |w_or;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_c        <= '0;
            r_v        <= 1'b0;
            r_corr     <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= r_s1_sum;
                r_c    <= w_carry_up ? w_pred_inc : r_s1_pred;
                r_v    <= r_s1_nz;
                r_corr <= w_carry_up;
            end
        end
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_cnt <= '0;
        end else if (w_out_xfer && r_corr && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = rst_n & w_adv1;
    assign bus.out_valid = r_s2_valid;
    assign bus.sum       = r_sum;
    assign bus.c         = r_c;
    assign bus.v         = r_v;
    assign bus.corr      = r_corr;
    assign bus.corr_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lods_pre_pipe.sv
// ============================================================================
// Module   : tb_lods_pre_pipe
// Brief    : Directed and streamed self-checking bench for lods_pre_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lods_pre_pipe;

    localparam int W  = 11;
    localparam int PW = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lods_pre_pipe_if #(.W(W), .PW(PW), .CW(CW)) bus ();

    lods_pre_pipe #(.W(W), .PW(PW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int msb_of(input logic [W:0] s);
        int r = 0;
        for (int i = 0; i <= W; i++) if (s[i]) r = i;
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.out_ready = 1'b0; bus.clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.corr_cnt !== 2'd0) begin
            bad++; $display("FAIL reset_valid_cnt: out_valid=%b corr_cnt=%0d expected 0 0", bus.out_valid, bus.corr_cnt);
        end
        total++;
        if (bus.sum !== 12'h0 || bus.c !== 4'd0 || bus.v !== 1'b0 || bus.corr !== 1'b0) begin
            bad++; $display("FAIL reset_data: sum=%h c=%0d v=%b corr=%b expected all 0", bus.sum, bus.c, bus.v, bus.corr);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic run_pair(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic [W:0] es, input logic [PW-1:0] ec, input logic ev,
                            input logic ecorr, input logic [CW-1:0] ecnt);
        int n = 0;
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!bus.out_valid) begin
            bad++; $display("FAIL %s_timeout: out_valid=0 expected 1", nm);
        end else if (bus.sum !== es || bus.c !== ec || bus.v !== ev || bus.corr !== ecorr) begin
            bad++;
            $display("FAIL %s: sum=%h c=%0d v=%b corr=%b expected sum=%h c=%0d v=%b corr=%b",
                     nm, bus.sum, bus.c, bus.v, bus.corr, es, ec, ev, ecorr);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.corr_cnt !== ecnt) begin
            bad++; $display("FAIL %s_cnt: corr_cnt=%0d expected %0d", nm, bus.corr_cnt, ecnt);
        end
    endtask

    task automatic test_directed;
        run_pair("zero",      11'h000, 11'h000, 12'h000, 4'd0,  1'b0, 1'b0, 2'd0);
        run_pair("carry_top", 11'h400, 11'h400, 12'h800, 4'd11, 1'b1, 1'b1, 2'd1);
        run_pair("all_ones",  11'h7FF, 11'h7FF, 12'hFFE, 4'd11, 1'b1, 1'b1, 2'd2);
        run_pair("one",       11'h001, 11'h000, 12'h001, 4'd0,  1'b1, 1'b0, 2'd2);
        run_pair("small_cy",  11'h003, 11'h001, 12'h004, 4'd2,  1'b1, 1'b1, 2'd3);
        run_pair("no_cy",     11'h005, 11'h002, 12'h007, 4'd2,  1'b1, 1'b0, 2'd3);
        run_pair("saturate",  11'h001, 11'h001, 12'h002, 4'd1,  1'b1, 1'b1, 2'd3);
    endtask

    task automatic test_clear;
        int n = 0;
        @(negedge clk);
        bus.a = 11'h001; bus.b = 11'h001; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.out_valid !== 1'b1 || bus.corr !== 1'b1 || bus.corr_cnt !== 2'd3) begin
            bad++; $display("FAIL clr_setup: out_valid=%b corr=%b corr_cnt=%0d expected 1 1 3", bus.out_valid, bus.corr, bus.corr_cnt);
        end
        bus.out_ready = 1'b1; bus.clr_cnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clr_cnt = 1'b0;
        total++;
        if (bus.corr_cnt !== 2'd0) begin
            bad++; $display("FAIL clr_priority: corr_cnt=%0d expected 0", bus.corr_cnt);
        end
        run_pair("after_clr", 11'h003, 11'h001, 12'h004, 4'd2, 1'b1, 1'b1, 2'd1);
    endtask

    task automatic test_backpressure;
        logic [W-1:0] pa [3] = '{11'h003, 11'h100, 11'h7FF};
        logic [W-1:0] pb [3] = '{11'h001, 11'h0FF, 11'h001};
        logic [W:0]   es [3] = '{12'h004, 12'h1FF, 12'h800};
        logic [PW-1:0] ec [3] = '{4'd2, 4'd8, 4'd11};
        int acc = 0;
        int first_block = -1;
        int got = 0;
        bit stable = 1'b1;
        bit xi;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            bus.a = pa[acc]; bus.b = pb[acc]; bus.in_valid = 1'b1;
            #1;
            if (bus.in_valid && bus.in_ready) acc++;
            else if (first_block < 0) first_block = cyc;
            if (cyc >= 2 && (bus.out_valid !== 1'b1 || bus.sum !== es[0] || bus.c !== ec[0])) stable = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (acc != 2 || first_block != 2) begin
            bad++; $display("FAIL bp_accept: accepted=%0d first_block=%0d expected 2 2", acc, first_block);
        end
        total++;
        if (!stable) begin
            bad++; $display("FAIL bp_stable: sum=%h c=%0d expected stable sum=%h c=%0d", bus.sum, bus.c, es[0], ec[0]);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            #1;
            xi = bus.in_valid & bus.in_ready;
            if (bus.out_valid) begin
                total++;
                if (bus.sum !== es[got] || bus.c !== ec[got]) begin
                    bad++; $display("FAIL bp_drain%0d: sum=%h c=%0d expected sum=%h c=%0d", got, bus.sum, bus.c, es[got], ec[got]);
                end
                got++;
            end
            @(posedge clk);
            @(negedge clk);
            if (xi) begin
                acc++;
                bus.in_valid = 1'b0;
            end
        end
        total++;
        if (got != 3 || acc != 3) begin
            bad++; $display("FAIL bp_drain_count: got=%0d accepted=%0d expected 3 3", got, acc);
        end
    endtask

    task automatic test_back_to_back;
        int got = 0;
        int first = -1;
        int last = -1;
        bit ready_ok = 1'b1;
        logic [W:0] es;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc < 5) begin
                bus.a = W'(cyc * 100); bus.b = W'(cyc * 7 + 1); bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc < 5 && !bus.in_ready) ready_ok = 1'b0;
            if (bus.out_valid) begin
                es = (W+1)'(got * 107 + 1);
                total++;
                if (bus.sum !== es || bus.c !== PW'(msb_of(es))) begin
                    bad++; $display("FAIL b2b%0d: sum=%h c=%0d expected sum=%h c=%0d", got, bus.sum, bus.c, es, msb_of(es));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (!ready_ok || got != 5 || last - first != 4) begin
            bad++; $display("FAIL b2b_rate: ready_ok=%b got=%0d span=%0d expected 1 5 4", ready_ok, got, last - first);
        end
    endtask

    task automatic test_midreset;
        bit seen = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.a = 11'h001; bus.b = 11'h001; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 11'h003; bus.b = 11'h001;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL mr_full: out_valid=%b in_ready=%b expected 1 0", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.corr_cnt !== 2'd0 || bus.sum !== 12'h0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL mr_reset: out_valid=%b corr_cnt=%0d sum=%h in_ready=%b expected 0 0 0 0",
                            bus.out_valid, bus.corr_cnt, bus.sum, bus.in_ready);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL mr_stale: out_valid seen=1 expected 0");
        end
    endtask

    task automatic test_random;
        localparam int N = 1500;
        logic [W-1:0] qa [$];
        logic [W-1:0] qb [$];
        logic [W-1:0] ea, eb;
        logic [W:0]   es, h_sum;
        logic [PW-1:0] h_c;
        logic h_v, h_corr, ecorr;
        int sent = 0, rcv = 0, cyc = 0, sel;
        bit xi = 1'b0, xo, stall = 1'b0;
        while (rcv < N && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (xi) bus.in_valid = 1'b0;
            if (!bus.in_valid && sent < N) begin
                sel = $urandom_range(0, 7);
                if (sel == 0) begin bus.a = '0; bus.b = '0; end
                else if (sel == 1) begin bus.a = '1; bus.b = '1; end
                else begin bus.a = W'($urandom); bus.b = W'($urandom); end
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                total++;
                if (bus.sum !== h_sum || bus.c !== h_c || bus.v !== h_v || bus.corr !== h_corr) begin
                    bad++; $display("FAIL rnd_stall: sum=%h c=%0d expected held sum=%h c=%0d", bus.sum, bus.c, h_sum, h_c);
                end
            end
            xi = bus.in_valid & bus.in_ready;
            xo = bus.out_valid & bus.out_ready;
            if (xi) begin
                qa.push_back(bus.a); qb.push_back(bus.b); sent++;
            end
            if (xo) begin
                total++;
                if (qa.size() == 0) begin
                    bad++; $display("FAIL rnd_extra: unexpected output sum=%h", bus.sum);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front();
                    es = {1'b0, ea} + {1'b0, eb};
                    ecorr = (es != 0) && (msb_of(es) > msb_of({1'b0, ea | eb}));
                    if (bus.sum !== es || bus.c !== PW'(msb_of(es)) || bus.v !== (es != 0) || bus.corr !== ecorr) begin
                        bad++;
                        $display("FAIL rnd_out%0d: sum=%h c=%0d v=%b corr=%b expected sum=%h c=%0d v=%b corr=%b",
                                 rcv, bus.sum, bus.c, bus.v, bus.corr, es, msb_of(es), (es != 0), ecorr);
                    end
                end
                rcv++;
            end
            stall = bus.out_valid & ~bus.out_ready;
            h_sum = bus.sum; h_c = bus.c; h_v = bus.v; h_corr = bus.corr;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (rcv != N || sent != N || qa.size() != 0) begin
            bad++; $display("FAIL rnd_count: sent=%0d received=%0d pending=%0d expected %0d %0d 0", sent, rcv, qa.size(), N, N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clear();
        test_backpressure();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
